// File: rtl/u409_flash_ctrl_if.sv
// u409_flash_ctrl_if: 68040-to-flash bus bundle.
// master: CPU/flash side drives ts_n, rnw, flash_space, a, f_rdy.
// slave: controller drives fa, f_en_n, f_read_n, f_write_n, f_rst_n, f_wp_n, f_ack, f_tea.
interface u409_flash_ctrl_if;
  logic ts_n, rnw, flash_space, f_rdy;
  logic [23:1] a, fa;
  logic f_en_n, f_read_n, f_write_n, f_rst_n, f_wp_n, f_ack, f_tea;
  modport master (
    output ts_n, rnw, flash_space, a, f_rdy,
    input fa, f_en_n, f_read_n, f_write_n, f_rst_n, f_wp_n, f_ack, f_tea
  );
  modport slave (
    input ts_n, rnw, flash_space, a, f_rdy,
    output fa, f_en_n, f_read_n, f_write_n, f_rst_n, f_wp_n, f_ack, f_tea
  );
endinterface

// File: rtl/u409_flash_ctrl.sv
// u409_flash_ctrl: 68040 flash cycle sequencer (reset pulse, strobe timing, ready wait, timeout).
// Ports: clk40, reset (async, active high), bus (u409_flash_ctrl_if.slave).
// Macro FLASH_WRITE_EN enables real write cycles; without it writes terminate without a strobe.
module u409_flash_ctrl #(
  parameter int RD_WAIT = 4,
  parameter int WR_WAIT = 3,
  parameter int RST_CYC = 16,
  parameter int TIMEOUT = 255
) (
  input logic clk40,
  input logic reset,
  u409_flash_ctrl_if.slave bus
);
`ifdef FLASH_WRITE_EN
  localparam bit WE = 1'b1;
`else
  localparam bit WE = 1'b0;
`endif
  typedef enum logic [2:0] {RSTP, IDLE, SETUP, STROBE, BUSY, ACK, ERR} state_t;
  state_t state;
  logic [7:0] cnt, strobe_len;
  logic [23:1] pend_a;
  logic rnw_q, pend, pend_rnw, hit, start_rnw, done;
  // A disabled write spends one strobe-less cycle in STROBE so it terminates two edges after TSn.
  always_comb begin
    hit = !bus.ts_n && bus.flash_space;
    start_rnw = pend ? pend_rnw : bus.rnw;
    strobe_len = rnw_q ? 8'(RD_WAIT) : WE ? 8'(WR_WAIT) : 8'd1;
    done = bus.f_rdy || (!rnw_q && !WE);
  end
  always_ff @(posedge clk40 or posedge reset) begin
    if (reset) begin
      state <= RSTP;
      cnt <= '0;
      rnw_q <= 1'b1;
      pend <= 1'b0;
      pend_rnw <= 1'b1;
      pend_a <= '0;
      bus.fa <= '0;
      bus.f_en_n <= 1'b1;
      bus.f_read_n <= 1'b1;
      bus.f_write_n <= 1'b1;
      bus.f_rst_n <= 1'b0;
      bus.f_wp_n <= 1'b0;
      bus.f_ack <= 1'b0;
      bus.f_tea <= 1'b0;
    end else begin
      case (state)
        RSTP: begin
          if (hit) begin
            pend <= 1'b1;
            pend_a <= bus.a;
            pend_rnw <= bus.rnw;
          end
          if (cnt == 8'(RST_CYC - 1)) begin
            state <= IDLE;
            cnt <= '0;
            bus.f_rst_n <= 1'b1;
          end else cnt <= cnt + 8'd1;
        end
        IDLE: if (pend || hit) begin
          state <= SETUP;
          cnt <= '0;
          pend <= 1'b0;
          rnw_q <= start_rnw;
          bus.fa <= pend ? pend_a : bus.a;
          bus.f_en_n <= 1'b0;
          bus.f_wp_n <= WE && !start_rnw;
        end
        SETUP: begin
          state <= STROBE;
          cnt <= '0;
          bus.f_read_n <= !rnw_q;
          bus.f_write_n <= !(WE && !rnw_q);
        end
        STROBE: if (cnt == strobe_len - 8'd1) begin
          cnt <= '0;
          bus.f_read_n <= 1'b1;
          bus.f_write_n <= 1'b1;
          if (done) begin
            state <= ACK;
            bus.f_ack <= 1'b1;
            bus.f_en_n <= 1'b1;
            bus.f_wp_n <= 1'b0;
          end else state <= BUSY;
        end else cnt <= cnt + 8'd1;
        BUSY: if (done) begin
          state <= ACK;
          bus.f_ack <= 1'b1;
          bus.f_en_n <= 1'b1;
          bus.f_wp_n <= 1'b0;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          state <= ERR;
          bus.f_tea <= 1'b1;
          bus.f_en_n <= 1'b1;
          bus.f_wp_n <= 1'b0;
        end else cnt <= cnt + 8'd1;
        default: begin
          state <= IDLE;
          bus.f_ack <= 1'b0;
          bus.f_tea <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_u409_flash_ctrl.sv
// tb_u409_flash_ctrl: randomized self-checking bench for u409_flash_ctrl against a timeline model.
module tb_u409_flash_ctrl;
  localparam int RD = 4, WR = 3, RC = 16, TO = 255;
`ifdef FLASH_WRITE_EN
  localparam bit WE = 1'b1;
`else
  localparam bit WE = 1'b0;
`endif
  logic clk40 = 1'b0, reset = 1'b1, chk_en = 1'b0;
  int passed = 0, total = 0;
  u409_flash_ctrl_if bus();
  u409_flash_ctrl #(.RD_WAIT(RD), .WR_WAIT(WR), .RST_CYC(RC), .TIMEOUT(TO)) dut (
    .clk40(clk40), .reset(reset), .bus(bus)
  );
  always #5 clk40 = ~clk40;
  // Model: rcnt = edges since reset release; a transaction is tracked by k = edges since its
  // start edge, L = strobe length and endk = edge of its termination pulse once decided.
  int rcnt = 0, k = 0, endk = -1, len = 0;
  bit pend = 1'b0, prnw = 1'b0, act = 1'b0, ok = 1'b1, m_rnw = 1'b0;
  logic [23:1] pa = '0, m_fa = '0;
  always @(posedge clk40 or posedge reset) begin
    if (reset) begin
      rcnt = 0;
      pend = 1'b0;
      act = 1'b0;
      m_fa = '0;
    end else if (rcnt < RC) begin
      rcnt++;
      if (!bus.ts_n && bus.flash_space) begin
        pend = 1'b1;
        pa = bus.a;
        prnw = bus.rnw;
      end
    end else if (!act) begin
      if (pend || (!bus.ts_n && bus.flash_space)) begin
        act = 1'b1;
        k = 0;
        ok = 1'b1;
        m_rnw = pend ? prnw : bus.rnw;
        m_fa = pend ? pa : bus.a;
        pend = 1'b0;
        len = m_rnw ? RD : (WE ? WR : 0);
        endk = (!WE && !m_rnw) ? 2 : -1;
      end
    end else begin
      k++;
      if (endk >= 0 && k > endk) act = 1'b0;
      else if (endk < 0 && k > len) begin
        if (bus.f_rdy) endk = k;
        else if (k == len + 1 + TO) begin
          endk = k;
          ok = 1'b0;
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
  endtask
  always @(negedge clk40) if (chk_en) begin
    chk("outputs", 32'({bus.f_rst_n, bus.f_en_n, bus.f_read_n, bus.f_write_n, bus.f_wp_n, bus.f_ack, bus.f_tea}),
        32'({rcnt >= RC,
             !(act && (endk < 0 || k < endk)),
             !(act && m_rnw && k >= 1 && k <= len),
             !(act && !m_rnw && k >= 1 && k <= len),
             act && WE && !m_rnw && (endk < 0 || k < endk),
             act && k == endk && ok,
             act && k == endk && !ok}));
    chk("fa", 32'(bus.fa), 32'(m_fa));
    chk("ack_tea_excl", 32'(bus.f_ack && bus.f_tea), 32'd0);
    chk("strobe_excl", 32'(!bus.f_read_n && !bus.f_write_n), 32'd0);
  end
  task automatic run_tx(input logic r, input logic [23:1] addr, input int rdy_at, output int n,
                        output int tea_seen, output int rd_lo, output int wr_lo, output int wp_hi);
    n = 0;
    tea_seen = 0;
    rd_lo = 0;
    wr_lo = 0;
    wp_hi = 0;
    @(posedge clk40);
    #1;
    bus.ts_n = 1'b0;
    bus.flash_space = 1'b1;
    bus.rnw = r;
    bus.a = addr;
    @(posedge clk40);
    #1;
    bus.ts_n = 1'b1;
    bus.flash_space = 1'b0;
    while (n < 400) begin
      @(posedge clk40);
      n++;
      #1;
      if (n == rdy_at) bus.f_rdy = 1'b1;
      rd_lo += int'(!bus.f_read_n);
      wr_lo += int'(!bus.f_write_n);
      wp_hi += int'(bus.f_wp_n);
      if (bus.f_ack || bus.f_tea) begin
        tea_seen = int'(bus.f_tea);
        break;
      end
    end
    @(posedge clk40);
    #1;
  endtask
  initial begin
    int n, tea_seen, rd_lo, wr_lo, wp_hi;
    bus.ts_n = 1'b1;
    bus.rnw = 1'b1;
    bus.flash_space = 1'b0;
    bus.a = '0;
    bus.f_rdy = 1'b1;
    #8 chk_en = 1'b1;
    #14;
    chk("reset_vals", 32'({bus.f_rst_n, bus.f_en_n, bus.f_read_n, bus.f_write_n, bus.f_wp_n, bus.f_ack, bus.f_tea}), 32'h38);
    chk("reset_fa", 32'(bus.fa), 32'd0);
    #5 reset = 1'b0;
    n = 0;
    while (n < 300) begin
      @(posedge clk40);
      n++;
      #1;
      if (bus.f_rst_n) break;
    end
    chk("rst_release_edges", n, 16);
    run_tx(1'b1, 23'h123456, -1, n, tea_seen, rd_lo, wr_lo, wp_hi);
    chk("read_ack_edge", n, 5);
    chk("read_strobe_len", rd_lo, 4);
    chk("read_fa", 32'(bus.fa), 32'h123456);
    chk("read_no_tea", tea_seen, 0);
`ifdef FLASH_WRITE_EN
    bus.f_rdy = 1'b0;
    run_tx(1'b0, 23'h00abcd, 14, n, tea_seen, rd_lo, wr_lo, wp_hi);
    chk("write_ack_edge", n, 15);
    chk("write_strobe_len", wr_lo, 3);
    chk("write_wp_cycles", wp_hi, 14);
`else
    run_tx(1'b0, 23'h00abcd, -1, n, tea_seen, rd_lo, wr_lo, wp_hi);
    chk("write_ack_edge", n, 2);
    chk("write_strobe_len", wr_lo, 0);
    chk("write_wp_cycles", wp_hi, 0);
`endif
    bus.f_rdy = 1'b0;
    run_tx(1'b1, 23'h7fffff, -1, n, tea_seen, rd_lo, wr_lo, wp_hi);
    chk("timeout_edge", n, 260);
    chk("timeout_tea", tea_seen, 1);
    bus.f_rdy = 1'b1;
    @(posedge clk40);
    #1;
    bus.ts_n = 1'b0;
    bus.flash_space = 1'b0;
    @(posedge clk40);
    #1;
    bus.ts_n = 1'b1;
    @(posedge clk40);
    #1;
    chk("ignore_no_space", 32'(bus.f_en_n), 32'd1);
    bus.ts_n = 1'b0;
    bus.flash_space = 1'b1;
    bus.rnw = 1'b1;
    bus.a = 23'h2aaaa;
    @(posedge clk40);
    #1;
    bus.ts_n = 1'b1;
    bus.flash_space = 1'b0;
    @(posedge clk40);
    @(posedge clk40);
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_strobe", 32'({bus.f_rst_n, bus.f_en_n, bus.f_read_n, bus.f_write_n, bus.f_wp_n, bus.f_ack, bus.f_tea}), 32'h38);
    chk("reset_mid_fa", 32'(bus.fa), 32'd0);
    @(posedge clk40);
    #3 reset = 1'b0;
    n = 0;
    while (n < 400) begin
      @(posedge clk40);
      n++;
      #1;
      if (n == 2) begin
        bus.ts_n = 1'b0;
        bus.flash_space = 1'b1;
        bus.rnw = 1'b1;
        bus.a = 23'h0f0f0f;
      end
      if (n == 3) begin
        bus.ts_n = 1'b1;
        bus.flash_space = 1'b0;
      end
      if (bus.f_ack) break;
    end
    chk("pending_ack_edge", n, 22);
    chk("pending_fa", 32'(bus.fa), 32'h0f0f0f);
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk40);
      #1;
      bus.ts_n = ($urandom_range(0, 5) != 0);
      bus.flash_space = ($urandom_range(0, 3) != 0);
      bus.rnw = 1'($urandom);
      bus.a = 23'($urandom);
      bus.f_rdy = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 999) == 0) begin
        #1 reset = 1'b1;
        @(posedge clk40);
        #3 reset = 1'b0;
      end
    end
    @(posedge clk40);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/u409_flash_ctrl.md
U409_FLASH_CTRL -- requirements
Module: u409_flash_ctrl

Interface
REQ-001 Parameter RD_WAIT, default 4: read strobe width in CLK40 cycles (1..15).
REQ-002 Parameter WR_WAIT, default 3: write strobe width in CLK40 cycles (1..15).
REQ-003 Parameter RST_CYC, default 16: F_RSTn low time after reset in cycles (1..255).
REQ-004 Parameter TIMEOUT, default 255: maximum F_RDY wait in cycles (1..255).
REQ-005 CLK40  in  1  system clock, all state on rising edge; one clock only.
REQ-006 RESET  in  1  asynchronous, active-high reset.
REQ-007 TSn  in  1  68040 transfer start, active low, one cycle.
REQ-008 RnW  in  1  1 = read, 0 = write; sampled with TSn.
REQ-009 FLASH_SPACE  in  1  address decode hit for flash; sampled with TSn.
REQ-010 A  in  23 [23:1]  CPU word address; sampled with TSn.
REQ-011 F_RDY  in  1  flash ready/busy, 1 = ready.
REQ-012 FA  out  23 [23:1]  latched flash address.
REQ-013 F_ENn, F_READn, F_WRITEn, F_RSTn  out  1 each  flash chip enable, output enable, write enable, reset; all active low.
REQ-014 F_WPn  out  1  flash write protect, 0 = protected.
REQ-015 F_ACK  out  1  one-cycle cycle-complete pulse to bus termination logic.
REQ-016 F_TEA  out  1  one-cycle timeout error pulse, replaces F_ACK.

Function
REQ-017 The FSM SHALL have states RSTP, IDLE, SETUP, STROBE, BUSY, ACK, ERR; all outputs registered.
- RSTP: F_RSTn=0 for RST_CYC cycles, then IDLE with F_RSTn=1.
- IDLE: on an edge sampling TSn=0 and FLASH_SPACE=1, latch A->FA and RnW, go to SETUP.
- SETUP (1 cycle): F_ENn=0, then STROBE.
- STROBE: F_READn (read) or F_WRITEn (write) =0 for exactly RD_WAIT/WR_WAIT cycles; F_ENn stays 0.
- After STROBE: F_RDY=1 -> ACK; else BUSY.
- BUSY: strobes high, F_ENn=0; F_RDY=1 -> ACK; TIMEOUT cycles without F_RDY -> ERR.
- ACK/ERR (1 cycle): F_ACK or F_TEA =1, F_ENn=1, then IDLE.
REQ-018 Read latency: F_ACK SHALL go high RD_WAIT+1 edges after the TSn sampling edge when F_RDY=1 throughout.
REQ-019 TSn with FLASH_SPACE=1 during RSTP SHALL be held pending and started on IDLE entry; TSn in any other non-IDLE state SHALL be ignored.
REQ-020 TSn with FLASH_SPACE=0 SHALL leave the FSM and all outputs unchanged.
REQ-021 F_ACK and F_TEA SHALL never be high in the same cycle; F_READn and F_WRITEn SHALL never both be low.
REQ-022 The BUSY counter SHALL clear on every SETUP entry; the strobe counter SHALL clear on every STROBE entry.

Reset
REQ-023 RESET=1 SHALL force state RSTP immediately, including mid-cycle, with outputs F_RSTn=0, F_ENn=1, F_READn=1, F_WRITEn=1, F_WPn=0, F_ACK=0, F_TEA=0, FA=0, pending cleared.
REQ-024 Release of RESET SHALL start the RST_CYC count on the first following edge.

Configuration
REQ-025 Macro FLASH_WRITE_EN defined: writes run SETUP/STROBE/BUSY with F_WPn=1 from SETUP through BUSY, otherwise 0.
REQ-026 Macro FLASH_WRITE_EN undefined: F_WRITEn and F_WPn SHALL be constant 1 and 0, and a write SHALL go SETUP -> ACK with no strobe.

Verification
REQ-027 Reset release, RST_CYC=16 -> F_RSTn low 16 cycles, then high; all other outputs at reset values.
REQ-028 Read, TSn=0, FLASH_SPACE=1, A=0x123456, F_RDY=1 -> FA=0x123456, F_READn low 4 cycles, F_ACK pulse 5 edges after sampling.
REQ-029 Write with FLASH_WRITE_EN, F_RDY low 10 cycles after strobe -> F_WRITEn low 3 cycles, F_WPn=1, F_ACK after F_RDY rises.
REQ-030 Write, F_RDY stuck 0, TIMEOUT=255 -> F_TEA one cycle after 255 BUSY cycles, no F_ACK, return to IDLE.
REQ-031 RESET asserted during STROBE -> all outputs at reset values the same cycle; TSn during RSTP serviced after 16 cycles.
REQ-032 Write without FLASH_WRITE_EN -> F_WRITEn stays 1, F_ACK 2 edges after the TSn sampling edge.
